// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with level interrupt for the CPU bridge bus.
// Registers: CTRL (En/Mode/IM), PRESET, COUNT (read-only). irq = pend & IM.
module timer_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StCnt  = 2'd2;
  localparam logic [1:0] StInt  = 2'd3;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic ctrl_wr;
  logic preset_wr;

  assign ctrl_wr   = we && (addr == AddrCtrl);
  assign preset_wr = we && (addr == AddrPreset);

  // Next-state: FSM update first, then a CTRL bus write overrides CTRL, pend and (for En=0) state.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    pend_d   = pend_q;
    preset_d = preset_q;
    count_d  = count_q;

    case (state_q)
      StIdle: begin
        if (en_q) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          // PRESET=0 lands here on the first CNT cycle, so it behaves like 1
          count_d = '0;
          pend_d  = 1'b1;
          state_d = StInt;
        end
      end
      default: begin // StInt
        if (mode_q == 2'b01) begin
          pend_d  = 1'b0;
          state_d = StLoad;
        end else begin
          // one-shot, and reserved modes 1x
          en_d    = 1'b0;
          state_d = StIdle;
        end
      end
    endcase

    if (ctrl_wr) begin
      en_d   = din[0];
      mode_d = din[2:1];
      im_d   = din[3];
      pend_d = 1'b0;
      if (!din[0]) state_d = StIdle;
    end

    if (preset_wr) preset_d = din;
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  // Combinational read mux.
  always_comb begin
    dout = '0;
    case (addr)
      AddrCtrl:   dout = {{(WIDTH-4){1'b0}}, im_q, mode_q, en_q};
      AddrPreset: dout = preset_q;
      AddrCount:  dout = count_q;
      default:    dout = '0;
    endcase
  end

  assign irq = pend_q & im_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with literal
// expectations, then randomized bus traffic against a behavioural model.
module tb_timer_counter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         we;
  logic [1:0]   addr;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         irq;

  int n_vec = 0;
  int n_err = 0;

  timer_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 about to load, 2 counting, 3 expired
  int          m_phase;
  logic        m_en, m_im, m_pend, m_valid = 1'b0;
  logic [1:0]  m_mode;
  logic [W-1:0] m_pre, m_cnt;

  always @(posedge clk) begin
    automatic int          ph  = m_phase;
    automatic logic [W-1:0] c  = m_cnt;
    automatic logic        p   = m_pend;
    automatic logic        e   = m_en;
    automatic logic [1:0]  md  = m_mode;
    automatic logic        im  = m_im;
    automatic logic [W-1:0] pr = m_pre;
    if (reset) begin
      m_phase <= 0; m_en <= 0; m_mode <= 0; m_im <= 0;
      m_pend <= 0; m_pre <= 0; m_cnt <= 0; m_valid <= 1'b1;
    end else if (m_valid) begin
      if (m_phase == 0) begin
        if (m_en) ph = 1;
      end else if (m_phase == 1) begin
        c = m_pre; ph = 2;
      end else if (m_phase == 2) begin
        if (!m_en) ph = 0;
        else if (m_cnt >= 2) c = m_cnt - 1;
        else begin c = 0; p = 1; ph = 3; end
      end else begin
        if (m_mode == 2'b01) begin p = 0; ph = 1; end
        else begin e = 0; ph = 0; end
      end
      if (we && addr == 2'd0) begin
        e = din[0]; md = din[2:1]; im = din[3]; p = 0;
        if (!din[0]) ph = 0;
      end
      if (we && addr == 2'd1) pr = din;
      m_phase <= ph; m_cnt <= c; m_pend <= p; m_en <= e;
      m_mode <= md; m_im <= im; m_pre <= pr;
    end
  end

  function automatic logic [W-1:0] model_read(input logic [1:0] a);
    if (a == 2'd0) return W'({m_im, m_mode, m_en});
    if (a == 2'd1) return m_pre;
    if (a == 2'd2) return m_cnt;
    return '0;
  endfunction

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid && !reset) begin
      n_vec++;
      if (dout !== model_read(addr) || irq !== (m_pend & m_im)) begin
        n_err++;
        $display("FAIL model t=%0t addr=%0d dout=%h irq=%b, required dout=%h irq=%b",
                 $time, addr, dout, irq, model_read(addr), m_pend & m_im);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc(input logic w, input logic [1:0] a, input logic [W-1:0] d);
    we = w; addr = a; din = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic peek(input string name, input logic [1:0] a, input logic [W-1:0] exp);
    we = 1'b0; addr = a; #1;
    check(name, dout, exp);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 2'd0; din = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // reset state
    peek("rst_ctrl", 2'd0, 0);
    peek("rst_preset", 2'd1, 0);
    peek("rst_count", 2'd2, 0);
    check("rst_irq", W'(irq), 0);

    // one-shot, PRESET=3
    cyc(1, 2'd1, 3);
    cyc(1, 2'd0, 'h9);
    cyc(0, 2'd2, 0);
    cyc(0, 2'd2, 0);
    peek("os_cnt3", 2'd2, 3);
    cyc(0, 2'd2, 0); peek("os_cnt2", 2'd2, 2);
    cyc(0, 2'd2, 0); peek("os_cnt1", 2'd2, 1);
    check("os_irq_e4", W'(irq), 0);
    cyc(0, 2'd2, 0); peek("os_cnt0", 2'd2, 0);
    check("os_irq_e5", W'(irq), 1);
    cyc(0, 2'd2, 0);
    check("os_irq_hold", W'(irq), 1);
    peek("os_ctrl", 2'd0, 'h8);
    cyc(1, 2'd0, 'h8);
    check("os_clr_irq", W'(irq), 0);
    cyc(0, 2'd2, 0);
    peek("os_cnt_stay", 2'd2, 0);

    // auto-reload, PRESET=2: pulse every 4 edges, counts 2,1,0,0
    cyc(1, 2'd1, 2);
    cyc(1, 2'd0, 'hB);
    for (int k = 1; k <= 12; k++) begin
      logic [W-1:0] seq [4];
      seq[0] = 2; seq[1] = 1; seq[2] = 0; seq[3] = 0;
      cyc(0, 2'd2, 0);
      check($sformatf("ar_irq_%0d", k), W'(irq), W'(k % 4 == 0));
      if (k >= 2) check($sformatf("ar_cnt_%0d", k), dout, seq[(k - 2) % 4]);
    end
    cyc(1, 2'd0, 0);

    // masked interrupt, PRESET=10
    cyc(1, 2'd1, 10);
    cyc(1, 2'd0, 'h1);
    for (int k = 1; k <= 14; k++) begin
      cyc(0, 2'd2, 0);
      check($sformatf("im0_irq_%0d", k), W'(irq), 0);
    end
    peek("im0_ctrl", 2'd0, 0);
    cyc(1, 2'd0, 'h8);
    check("im0_after_wr", W'(irq), 0);

    // freeze, PRESET write while frozen, re-enable reloads
    cyc(1, 2'd1, 100);
    cyc(1, 2'd0, 'h1);
    begin
      int guard = 0;
      addr = 2'd2; #1;
      while (dout != 95 && guard < 200) begin
        cyc(0, 2'd2, 0);
        guard++;
      end
      if (guard >= 200) begin
        n_vec++; n_err++;
        $display("FAIL frz_timeout got=%0d required=95", dout);
      end
    end
    cyc(1, 2'd0, 0);
    peek("frz_94", 2'd2, 94);
    cyc(1, 2'd1, 7);
    cyc(0, 2'd2, 0);
    cyc(0, 2'd2, 0);
    peek("frz_hold", 2'd2, 94);
    cyc(1, 2'd0, 'h1);
    cyc(0, 2'd2, 0);
    cyc(0, 2'd2, 0);
    peek("frz_reload", 2'd2, 7);
    cyc(0, 2'd2, 0);
    reset = 1'b1;
    cyc(0, 2'd2, 0);
    reset = 1'b0;
    peek("mid_rst_cnt", 2'd2, 0);
    peek("mid_rst_pre", 2'd1, 0);
    peek("mid_rst_ctrl", 2'd0, 0);
    check("mid_rst_irq", W'(irq), 0);

    // randomized traffic checked by the model process
    for (int i = 0; i < 4000; i++) begin
      logic         w;
      logic [1:0]   a;
      logic [W-1:0] d;
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      if (a == 2'd1) d = W'($urandom_range(0, 9));
      else           d = W'($urandom);
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      cyc(w, a, d);
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
